// File: rtl/spi_like_bus_master_if.sv
// Requester handshake and shared serial bus signals of spi_like_bus_master.
// The master modport is the bus master's view; the slave modport is the environment's view.
interface spi_like_bus_master_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]        REQ;
  logic [N_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [N_REQ-1:0]        GNT;
  logic                    BUSY;
  logic                    DONE;
  logic [DATA_W-1:0]       RDATA;
  logic                    BUS_CLK;
  logic                    BUS_RX;
  logic                    BUS_TX;

  modport master (
    input  REQ, REQ_ADDR, BUS_TX,
    output GNT, BUSY, DONE, RDATA, BUS_CLK, BUS_RX
  );

  modport slave (
    output REQ, REQ_ADDR, BUS_TX,
    input  GNT, BUSY, DONE, RDATA, BUS_CLK, BUS_RX
  );
endinterface

// File: rtl/spi_like_bus_master.sv
// Round-robin arbitrated serial bus master: shifts an address out LSB first on BUS_RX,
// then shifts a data byte in LSB first from BUS_TX, and returns it with a DONE pulse.
module spi_like_bus_master #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input logic                   CLK,
  input logic                   RST_N,
  spi_like_bus_master_if.master bus
);

  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CYC_W   = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CYC_W-1:0] CYC_RISE  = CYC_W'(CLK_DIV - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FINISH
  } state_e;

  state_e              state_q,   state_d;
  logic [PTR_W-1:0]    ptr_q,     ptr_d;
  logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0]    gnt_q,     gnt_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic                bus_clk_q, bus_clk_d;
  logic                bus_rx_q,  bus_rx_d;
  logic [CYC_W-1:0]    cyc_q,     cyc_d;
  logic [BIT_W-1:0]    bit_q,     bit_d;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;

  logic                arb_found;
  logic [PTR_W-1:0]    arb_idx;
  logic [N_REQ-1:0]    arb_onehot;
  logic [N_REQ-1:0]    req_sh;
  logic [ADDR_W-1:0]   sel_addr;
  int unsigned         arb_cand;

  // Round-robin search: first active request at or after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = 0;
    req_sh    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      arb_cand = (32'(ptr_q) + i) % N_REQ;
      req_sh   = bus.REQ >> arb_cand;
      if (!arb_found && req_sh[0]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(arb_cand);
      end
    end
    arb_onehot = N_REQ'(arb_found) << arb_idx;
    sel_addr   = ADDR_W'(bus.REQ_ADDR >> (32'(arb_idx) * ADDR_W));
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    bus_clk_d = bus_clk_q;
    bus_rx_d  = bus_rx_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;

    unique case (state_q)
      ST_IDLE: begin
        bus_clk_d = 1'b1;
        bus_rx_d  = 1'b0;
        if (arb_found) begin
          // The first bit period starts on the grant edge: BUS_CLK falls with bit 0 on BUS_RX.
          state_d   = ST_ADDR;
          gnt_idx_d = arb_idx;
          gnt_d     = arb_onehot;
          busy_d    = 1'b1;
          addr_sh_d = sel_addr >> 1;
          data_sh_d = '0;
          bus_clk_d = 1'b0;
          bus_rx_d  = sel_addr[0];
          cyc_d     = '0;
          bit_d     = '0;
        end
      end

      ST_ADDR: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CYC_RISE) begin
          bus_clk_d = 1'b1;
        end
        if (cyc_q == CYC_LAST) begin
          cyc_d     = '0;
          bus_clk_d = 1'b0;
          if (bit_q == ADDR_LAST) begin
            state_d  = ST_DATA;
            bit_d    = '0;
            bus_rx_d = 1'b0;
          end else begin
            bit_d     = bit_q + 1'b1;
            bus_rx_d  = addr_sh_q[0];
            addr_sh_d = addr_sh_q >> 1;
          end
        end
      end

      ST_DATA: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CYC_RISE) begin
          bus_clk_d = 1'b1;
        end
        // BUS_TX is taken on the last cycle of the high phase, i.e. as the bit period ends.
        if (cyc_q == CYC_LAST) begin
          cyc_d     = '0;
          data_sh_d = (data_sh_q >> 1) | (DATA_W'(bus.BUS_TX) << (DATA_W - 1));
          if (bit_q == DATA_LAST) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            rdata_d = (data_sh_q >> 1) | (DATA_W'(bus.BUS_TX) << (DATA_W - 1));
            gnt_d   = '0;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d     = bit_q + 1'b1;
            bus_clk_d = 1'b0;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        ptr_d   = (gnt_idx_q == PTR_LAST) ? '0 : gnt_idx_q + 1'b1;
        cyc_d   = '0;
        bit_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      bus_clk_q <= 1'b1;
      bus_rx_q  <= 1'b0;
      cyc_q     <= '0;
      bit_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      bus_clk_q <= bus_clk_d;
      bus_rx_q  <= bus_rx_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.RDATA   = rdata_q;
  assign bus.BUS_CLK = bus_clk_q;
  assign bus.BUS_RX  = bus_rx_q;

endmodule

// File: tb/tb_spi_like_bus_master.sv
// Scoreboard bench for spi_like_bus_master: a default build (CLK_DIV=2) and a CLK_DIV=1 build,
// each with a behavioural slave population on its serial bus.
module tb_spi_like_bus_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  spi_like_bus_master_if #(.N_REQ(4), .ADDR_W(8), .DATA_W(8)) b0 ();
  spi_like_bus_master_if #(.N_REQ(4), .ADDR_W(8), .DATA_W(8)) b1 ();

  spi_like_bus_master #(.N_REQ(4), .ADDR_W(8), .DATA_W(8), .CLK_DIV(2)) dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(b0.master)
  );
  spi_like_bus_master #(.N_REQ(4), .ADDR_W(8), .DATA_W(8), .CLK_DIV(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(b1.master)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [7:0] slave_data(input logic [7:0] a);
    case (a)
      8'h1A:   return 8'h5D;
      8'h1B:   return 8'h3F;
      8'h2A:   return 8'h41;
      8'h2B:   return 8'h6C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave population, bus 0: capture the address on BUS_CLK rises, then return data LSB first.
  logic       prev_clk0 = 1'b1;
  int         bcnt0     = 0;
  logic [7:0] sh0       = '0;
  logic [7:0] last_addr0 = '0;
  logic [7:0] d0;
  always @(negedge clk) begin
    if (b0.BUSY !== 1'b1) begin
      bcnt0     = 0;
      b0.BUS_TX = 1'b0;
    end else if (b0.BUS_CLK === 1'b1 && prev_clk0 === 1'b0) begin
      if (bcnt0 < 8) begin
        sh0 = {b0.BUS_RX, sh0[7:1]};
        if (bcnt0 == 7) last_addr0 = sh0;
      end else if (bcnt0 < 16) begin
        d0        = slave_data(last_addr0);
        b0.BUS_TX = d0[bcnt0-8];
      end
      bcnt0++;
    end
    prev_clk0 = b0.BUS_CLK;
  end

  logic       prev_clk1 = 1'b1;
  int         bcnt1     = 0;
  int         tog_err1  = 0;
  logic [7:0] sh1       = '0;
  logic [7:0] last_addr1 = '0;
  logic [7:0] d1;
  always @(negedge clk) begin
    if (b1.BUSY === 1'b1 && b1.BUS_CLK === prev_clk1) tog_err1++;
    if (b1.BUSY !== 1'b1) begin
      bcnt1     = 0;
      b1.BUS_TX = 1'b0;
    end else if (b1.BUS_CLK === 1'b1 && prev_clk1 === 1'b0) begin
      if (bcnt1 < 8) begin
        sh1 = {b1.BUS_RX, sh1[7:1]};
        if (bcnt1 == 7) last_addr1 = sh1;
      end else if (bcnt1 < 16) begin
        d1        = slave_data(last_addr1);
        b1.BUS_TX = d1[bcnt1-8];
      end
      bcnt1++;
    end
    prev_clk1 = b1.BUS_CLK;
  end

  // Monitors: time the grant, pop the scoreboard on every DONE.
  int         g_cyc0 = 0, last_g0 = -1, gcount0 = 0, dcount0 = 0;
  logic [3:0] prev_gnt0 = '0;
  exp_t       e0;
  always @(negedge clk) begin
    if (b0.GNT != 4'b0 && prev_gnt0 == 4'b0) begin
      g_cyc0  = cyc;
      last_g0 = onehot_idx(b0.GNT);
      gcount0++;
    end
    prev_gnt0 = b0.GNT;
    if (b0.DONE === 1'b1) begin
      dcount0++;
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut0_unexpected_done: got DONE expected none");
      end else begin
        e0 = q0.pop_front();
        check("dut0_grant_idx", last_g0, e0.idx);
        check("dut0_rdata", b0.RDATA, e0.data);
        check("dut0_latency", cyc - g_cyc0, e0.lat);
      end
    end
  end

  int         g_cyc1 = 0, last_g1 = -1, dcount1 = 0;
  logic [3:0] prev_gnt1 = '0;
  exp_t       e1;
  always @(negedge clk) begin
    if (b1.GNT != 4'b0 && prev_gnt1 == 4'b0) begin
      g_cyc1  = cyc;
      last_g1 = onehot_idx(b1.GNT);
    end
    prev_gnt1 = b1.GNT;
    if (b1.DONE === 1'b1) begin
      dcount1++;
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_done: got DONE expected none");
      end else begin
        e1 = q1.pop_front();
        check("dut1_grant_idx", last_g1, e1.idx);
        check("dut1_rdata", b1.RDATA, e1.data);
        check("dut1_latency", cyc - g_cyc1, e1.lat);
      end
    end
  end

  task automatic wait_dones(input int inst, input int target, input string name);
    int n = 0;
    while (((inst == 1) ? dcount1 : dcount0) < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, (((inst == 1) ? dcount1 : dcount0) >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_gnt0(input logic [3:0] mask, input string name);
    int n = 0;
    while (b0.GNT !== mask && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_gnt_seen"}, b0.GNT, mask);
  endtask

  logic [7:0] addrs[4] = '{8'h1A, 8'h1B, 8'h2A, 8'h2B};
  logic [7:0] datas[4] = '{8'h5D, 8'h3F, 8'h41, 8'h6C};
  int         base;
  int         gbefore;

  initial begin
    rst_n       = 1'b0;
    b0.REQ      = '0;
    b0.REQ_ADDR = {8'h2B, 8'h2A, 8'h1B, 8'h1A};
    b1.REQ      = '0;
    b1.REQ_ADDR = {24'h0, 8'h2A};
    repeat (3) @(negedge clk);
    check("rst_gnt", b0.GNT, 0);
    check("rst_busy", b0.BUSY, 0);
    check("rst_done", b0.DONE, 0);
    check("rst_rdata", b0.RDATA, 0);
    check("rst_bus_clk", b0.BUS_CLK, 1);
    check("rst_bus_rx", b0.BUS_RX, 0);
    check("rst_bus_clk_div1", b1.BUS_CLK, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read from requester 0
    q0.push_back('{idx: 0, data: 8'h5D, lat: 64});
    b0.REQ = 4'b0001;
    wait_dones(0, 1, "single");
    b0.REQ = '0;
    check("single_addr_bits", last_addr0, 8'h1A);
    repeat (3) @(negedge clk);

    // Four-slave sweep, one requester at a time
    for (int i = 0; i < 4; i++) begin
      base = dcount0;
      q0.push_back('{idx: i, data: datas[i], lat: 64});
      b0.REQ = 4'(1 << i);
      wait_dones(0, base + 1, "sweep");
      b0.REQ = '0;
      check("sweep_addr_bits", last_addr0, addrs[i]);
      repeat (2) @(negedge clk);
    end

    // Round robin with all requesters, then narrow to 0101 while 2 is granted
    base = dcount0;
    q0.push_back('{idx: 0, data: 8'h5D, lat: 64});
    q0.push_back('{idx: 1, data: 8'h3F, lat: 64});
    q0.push_back('{idx: 2, data: 8'h41, lat: 64});
    q0.push_back('{idx: 3, data: 8'h6C, lat: 64});
    q0.push_back('{idx: 0, data: 8'h5D, lat: 64});
    q0.push_back('{idx: 1, data: 8'h3F, lat: 64});
    q0.push_back('{idx: 2, data: 8'h41, lat: 64});
    q0.push_back('{idx: 0, data: 8'h5D, lat: 64});
    b0.REQ = 4'b1111;
    wait_dones(0, base + 6, "rr_first6");
    wait_gnt0(4'b0100, "rr_grant2");
    b0.REQ = 4'b0101;
    wait_dones(0, base + 8, "rr_last2");
    b0.REQ = '0;
    repeat (3) @(negedge clk);

    // Requester 1 drops REQ 10 cycles into its transaction
    base = dcount0;
    q0.push_back('{idx: 1, data: 8'h3F, lat: 64});
    b0.REQ = 4'b0010;
    wait_gnt0(4'b0010, "drop");
    repeat (10) @(negedge clk);
    b0.REQ = '0;
    wait_dones(0, base + 1, "drop");
    gbefore = gcount0;
    repeat (100) @(negedge clk);
    check("drop_no_regrant", gcount0, gbefore);

    // Asynchronous reset early in bit period 5 (BUS_CLK low, BUS_RX=1 for address 8'h2A)
    base             = dcount0;
    b0.REQ_ADDR[7:0] = 8'h2A;
    b0.REQ           = 4'b0001;
    wait_gnt0(4'b0001, "areset");
    repeat (19) @(negedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    check("areset_bus_clk", b0.BUS_CLK, 1);
    check("areset_bus_rx", b0.BUS_RX, 0);
    check("areset_gnt", b0.GNT, 0);
    check("areset_busy", b0.BUSY, 0);
    repeat (3) @(negedge clk);
    check("areset_no_done", dcount0, base);
    q0.push_back('{idx: 0, data: 8'h41, lat: 64});
    rst_n = 1'b1;
    wait_dones(0, base + 1, "areset_fresh");
    b0.REQ = '0;
    check("areset_fresh_addr", last_addr0, 8'h2A);
    b0.REQ_ADDR[7:0] = 8'h1A;
    repeat (3) @(negedge clk);

    // CLK_DIV=1 build
    q1.push_back('{idx: 0, data: 8'h41, lat: 32});
    b1.REQ = 4'b0001;
    wait_dones(1, 1, "div1");
    b1.REQ = '0;
    check("div1_addr_bits", last_addr1, 8'h2A);
    check("div1_bus_clk_toggle_errors", tog_err1, 0);
    repeat (5) @(negedge clk);

    check("dut0_queue_drained", q0.size(), 0);
    check("dut1_queue_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_like_bus_master.md
Name: spi_like_bus_master

Overview:
- Single master for the shared serial slave bus. Drives the common RX line and bus clock; the addressed slave_device returns its data byte on TX.
- Accepts byte-read requests from up to N_REQ on-chip requesters and arbitrates among them round-robin.
- Sequences each transaction: 8 address bits out, LSB first, then 8 data bits in, LSB first.
- Returns the read byte to the granted requester with a one-cycle DONE pulse.

Parameters:
N_REQ, 4, number of requesters (1..8)
ADDR_W, 8, slave address width shifted out
DATA_W, 8, data width shifted in
CLK_DIV, 2, system cycles per bus-clock half period (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  N_REQ  per-requester read request, level, held until DONE
REQ_ADDR  input  N_REQ*ADDR_W  per-requester slave address, slice i = requester i
GNT  output  N_REQ  one-hot grant, held for the whole transaction
BUSY  output  1  transaction in progress
DONE  output  1  one-cycle pulse; RDATA valid, for the requester in GNT
RDATA  output  DATA_W  last received byte, held until next DONE
BUS_CLK  output  1  serial bus clock to slaves, idles high
BUS_RX  output  1  serial address line to all slaves (slave RX)
BUS_TX  input  1  serial data from slaves (slave TX lines, muxed/OR'd externally)

Behaviour:
- Reset, asynchronous, RST_N=0:
  - State IDLE, GNT=0, BUSY=0, DONE=0, RDATA=0, BUS_CLK=1, BUS_RX=0.
  - Round-robin pointer = 0, all counters = 0.
  - Applies immediately, including mid-transaction. The partial transaction is dropped with no DONE.
- Bit period = 2*CLK_DIV system cycles:
  - BUS_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Slaves sample BUS_RX on the BUS_CLK rising edge.
- FSM states IDLE -> ADDR -> DATA -> FINISH -> IDLE.
- IDLE:
  - If any REQ is high, select the first requester at or after the pointer, cyclically.
  - On that edge: set GNT one-hot, BUSY=1, latch that requester's REQ_ADDR slice into the shift register, go to ADDR.
- ADDR, ADDR_W bit periods:
  - At each bit-period start, on the same edge BUS_CLK falls, BUS_RX = next address bit, LSB first.
  - BUS_RX stable for the whole bit period.
- DATA, DATA_W bit periods:
  - BUS_RX=0.
  - BUS_TX sampled on the last system cycle of each high phase, shifted in LSB first.
- FINISH, 1 cycle:
  - DONE=1, RDATA=shifted byte, GNT=0, BUSY=0.
  - Pointer = granted index + 1, mod N_REQ.
  - Back to IDLE. Earliest next GNT is the cycle after DONE.
- Latency:
  - GNT rises 1 cycle after REQ is sampled in IDLE.
  - DONE rises (ADDR_W+DATA_W)*2*CLK_DIV cycles after GNT rises. That is 64 cycles at defaults.
- Request and address changes mid-transaction:
  - REQ deassertion is ignored; the transaction completes and DONE is issued.
  - A requester must hold REQ to be rearbitrated.
  - REQ_ADDR changes after grant are ignored (address latched).
- Simultaneous requests: only one grant. Other requesters wait; fairness comes from the pointer.
- BUS_CLK returns high at the end of the final high phase and stays high in IDLE/FINISH.
- No glitches on BUS_CLK or BUS_RX: both are driven directly from flops.

Test Plan:
- Single read: REQ=4'b0001, REQ_ADDR[7:0]=8'h1A; bus model slave at 8'h1A returns 8'h5D.
  - BUS_RX at BUS_CLK rising edges = 0,1,0,1,1,0,0,0.
  - DONE exactly 64 cycles after GNT=4'b0001; RDATA=8'h5D.
- Four-slave sweep: requesters 0..3 addresses 8'h1A, 8'h1B, 8'h2A, 8'h2B; slaves return 8'h5D, 8'h3F, 8'h41, 8'h6C.
  - Requests raised one at a time; each RDATA matches its slave's data.
  - Unaddressed slaves leave BUS_TX=0.
- Round-robin: REQ=4'b1111 held throughout.
  - Grant order 0,1,2,3,0.
  - Then after grant 2 with REQ=4'b0101: next grant is 0, not 2.
- Mid-transaction REQ drop: deassert REQ 10 cycles after GNT.
  - DONE still pulses at cycle 64 with the correct RDATA.
  - No regrant to that requester.
- Async reset mid-ADDR: pull RST_N low at cycle 20 of a transaction.
  - Immediately BUS_CLK=1, BUS_RX=0, GNT=0, BUSY=0; no DONE.
  - After release with REQ still high, a fresh transaction to requester 0 completes correctly.
- CLK_DIV=1 build: single read of 8'h2A returning 8'h41.
  - DONE 32 cycles after GNT; BUS_CLK toggles every cycle.
